// File: rtl/i2c_req_sched_pkg.sv
// Shared definitions for the I2C request scheduler.
// Holds the I2C field widths, counter widths, scheduler state encoding
// (3-bit, same values the I2C master side decodes) and the latched
// transaction payload type.
package i2c_req_sched_pkg;

    localparam int unsigned I2C_ADDR_W = 7;
    localparam int unsigned I2C_DATA_W = 8;
    localparam int unsigned TMO_W      = 16;
    localparam int unsigned GAP_W      = 8;

    // Scheduler state encoding
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LAUNCH    = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_ABORT     = 3'd4,
        ST_ACK       = 3'd5,
        ST_GAP       = 3'd6
    } sched_state_t;

    // One byte-write transaction as handed to the I2C master
    typedef struct packed {
        logic [I2C_ADDR_W-1:0] addr;
        logic                  rw;
        logic [I2C_DATA_W-1:0] data;
    } i2c_txn_t;

endpackage

// File: rtl/i2c_req_sched_rr_pick.sv
// Combinational round-robin picker (rr_pick).
// Searches the request vector starting one above the last granted index,
// wrapping around, and returns the first set position.
//   req    : request vector, one bit per requester
//   last   : index of the previously granted requester
//   winner : index of the selected requester (0 when none found)
//   found  : 1 when at least one request bit is set
module i2c_req_sched_rr_pick
    import i2c_req_sched_pkg::*;
#(
    parameter int unsigned NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] last,
    output logic [$clog2(NREQ)-1:0] winner,
    output logic                    found
);

    localparam int unsigned IDW = $clog2(NREQ);

    // Offset k=1 is the highest-priority position, k=NREQ is last itself
    always_comb begin
        int unsigned idx;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = (32'(last) + k) % NREQ;
            if (!found && req[IDW'(idx)]) begin
                found  = 1'b1;
                winner = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/i2c_req_sched.sv
// Round-robin scheduler sharing one I2C byte-write master between NREQ
// requesters. Latches the winning request, strobes the master, tracks its
// busy flag with a timeout, returns a one-cycle ack (plus error flag) to the
// granted requester and enforces an idle gap before the next grant.
// Ports:
//   clk, reset_n        : clock, synchronous active-low reset
//   req_valid/addr/rw/data : per-requester request level and fields
//   req_ack, req_err    : one-cycle completion pulse and its error flag
//   grant_id            : current / last granted requester
//   active              : high from grant through end of gap
//   drv_go, drv_abort   : one-cycle launch / abort strobes to the master
//   drv_addr/rw/data    : latched transaction fields for the master
//   drv_busy            : master busy flag
module i2c_req_sched
    import i2c_req_sched_pkg::*;
#(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned GAP     = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [NREQ*I2C_ADDR_W-1:0] req_addr,
    input  logic [NREQ-1:0]            req_rw,
    input  logic [NREQ*I2C_DATA_W-1:0] req_data,
    output logic [NREQ-1:0]            req_ack,
    output logic                       req_err,
    output logic [$clog2(NREQ)-1:0]    grant_id,
    output logic                       active,
    output logic                       drv_go,
    output logic [I2C_ADDR_W-1:0]      drv_addr,
    output logic                       drv_rw,
    output logic [I2C_DATA_W-1:0]      drv_data,
    output logic                       drv_abort,
    input  logic                       drv_busy
);

    localparam int unsigned IDW = $clog2(NREQ);
    // Last counter value still allowed to wait; GAP=0 never reaches ST_GAP
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP - 1);

    sched_state_t      state;
    logic [IDW-1:0]    last_grant;
    logic [TMO_W-1:0]  tmo_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic [TMO_W-1:0]  tmo_inc_c;
    logic [IDW-1:0]    pick_id_c;
    logic              pick_found_c;
    logic              tmo_hit_c;
    i2c_txn_t          req_txn_c [NREQ];

    // Unpack the flat request buses into per-requester payloads
    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            req_txn_c[i].addr = req_addr[i*I2C_ADDR_W +: I2C_ADDR_W];
            req_txn_c[i].rw   = req_rw[i];
            req_txn_c[i].data = req_data[i*I2C_DATA_W +: I2C_DATA_W];
        end
    end

    i2c_req_sched_rr_pick #(
        .NREQ (NREQ)
    ) u_rr_pick (
        .req    (req_valid),
        .last   (last_grant),
        .winner (pick_id_c),
        .found  (pick_found_c)
    );

    // Saturating timeout counter; the >= compare keeps the abort reachable
    // even if the counter ran past TMO_LAST while waiting for busy to drop
    assign tmo_inc_c = (tmo_cnt == {TMO_W{1'b1}}) ? tmo_cnt : tmo_cnt + TMO_W'(1);
    assign tmo_hit_c = (tmo_cnt >= TMO_LAST);

    // Scheduler FSM; strobes default low and are raised on entry to the
    // state in which they are visible
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            last_grant <= IDW'(NREQ - 1);
            tmo_cnt    <= '0;
            gap_cnt    <= '0;
            grant_id   <= '0;
            active     <= 1'b0;
            drv_go     <= 1'b0;
            drv_addr   <= '0;
            drv_rw     <= 1'b0;
            drv_data   <= '0;
            drv_abort  <= 1'b0;
            req_ack    <= '0;
            req_err    <= 1'b0;
        end else begin
            drv_go    <= 1'b0;
            drv_abort <= 1'b0;
            req_ack   <= '0;
            req_err   <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (pick_found_c && !drv_busy) begin
                        drv_addr <= req_txn_c[pick_id_c].addr;
                        drv_rw   <= req_txn_c[pick_id_c].rw;
                        drv_data <= req_txn_c[pick_id_c].data;
                        grant_id <= pick_id_c;
                        active   <= 1'b1;
                        tmo_cnt  <= '0;
                        drv_go   <= 1'b1;
                        state    <= ST_LAUNCH;
                    end
                end

                ST_LAUNCH: begin
                    state <= ST_WAIT_BUSY;
                end

                // Waiting for the master to pick up the launch
                ST_WAIT_BUSY: begin
                    tmo_cnt <= tmo_inc_c;
                    if (drv_busy) begin
                        state <= ST_WAIT_DONE;
                    end else if (tmo_hit_c) begin
                        drv_abort <= 1'b1;
                        state     <= ST_ABORT;
                    end
                end

                // Waiting for the stop condition; busy low wins over timeout
                ST_WAIT_DONE: begin
                    tmo_cnt <= tmo_inc_c;
                    if (!drv_busy) begin
                        req_ack[grant_id] <= 1'b1;
                        req_err           <= 1'b0;
                        state             <= ST_ACK;
                    end else if (tmo_hit_c) begin
                        drv_abort <= 1'b1;
                        state     <= ST_ABORT;
                    end
                end

                ST_ABORT: begin
                    req_ack[grant_id] <= 1'b1;
                    req_err           <= 1'b1;
                    state             <= ST_ACK;
                end

                ST_ACK: begin
                    last_grant <= grant_id;
                    gap_cnt    <= '0;
                    if (GAP == 0) begin
                        active <= 1'b0;
                        state  <= ST_IDLE;
                    end else begin
                        state <= ST_GAP;
                    end
                end

                // Bus-free gap; requests are not looked at here
                ST_GAP: begin
                    if (gap_cnt >= GAP_LAST) begin
                        active <= 1'b0;
                        state  <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_req_sched.sv
// Self-checking bench for i2c_req_sched: a transaction-level model predicts
// the round-robin winner, latched fields, abort/ack timing and error flag
// from the master busy profile the bench plays back.
module tb_i2c_req_sched;

    localparam int NREQ = 4;
    localparam int TMO  = 16;
    localparam int GP   = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  req_valid;
    logic [27:0] req_addr;
    logic [3:0]  req_rw;
    logic [31:0] req_data;
    logic [3:0]  req_ack;
    logic        req_err;
    logic [1:0]  grant_id;
    logic        active;
    logic        drv_go;
    logic [6:0]  drv_addr;
    logic        drv_rw;
    logic [7:0]  drv_data;
    logic        drv_abort;
    logic        drv_busy;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [3:0] m_valid;
    logic [6:0] m_addr [4];
    logic       m_rw   [4];
    logic [7:0] m_data [4];
    int         m_last;

    always #5 clk = ~clk;

    i2c_req_sched #(
        .NREQ    (NREQ),
        .TIMEOUT (TMO),
        .GAP     (GP)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_rw    (req_rw),
        .req_data  (req_data),
        .req_ack   (req_ack),
        .req_err   (req_err),
        .grant_id  (grant_id),
        .active    (active),
        .drv_go    (drv_go),
        .drv_addr  (drv_addr),
        .drv_rw    (drv_rw),
        .drv_data  (drv_data),
        .drv_abort (drv_abort),
        .drv_busy  (drv_busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < 4; i++) begin
            req_valid[i]       = m_valid[i];
            req_addr[i*7 +: 7] = m_addr[i];
            req_rw[i]          = m_rw[i];
            req_data[i*8 +: 8] = m_data[i];
        end
    endtask

    task automatic new_fields(input int i);
        m_addr[i] = 7'($urandom);
        m_rw[i]   = 1'($urandom);
        m_data[i] = 8'($urandom);
    endtask

    // First valid requester after the last one served, wrapping
    function automatic int rr_winner();
        for (int k = 1; k <= 4; k++) begin
            if (m_valid[(m_last + k) % 4]) return (m_last + k) % 4;
        end
        return -1;
    endfunction

    // Master busy as seen in cycle t after the drv_go cycle (t=0)
    function automatic bit busy_prof(input int t, input int rise, input int fall);
        return (rise > 0) && (t >= rise) && (fall == 0 || t < fall);
    endfunction

    function automatic logic [31:0] all_outs();
        return 32'({req_ack, req_err, grant_id, active, drv_go, drv_addr,
                    drv_rw, drv_data, drv_abort});
    endfunction

    // Called at a negedge; holds reset for n cycles checking every output is 0
    task automatic apply_reset(input int n);
        reset_n  = 1'b0;
        drv_busy = 1'b0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            check_eq("reset_outs", all_outs(), 32'd0);
        end
        reset_n = 1'b1;
        m_last  = 3;
    endtask

    // Called at the negedge of an IDLE cycle with requests pending. The
    // master finishes cleanly if busy rises and falls within TIMEOUT wait
    // cycles (cycles 1..TMO); ack then follows the first busy-low cycle.
    // Otherwise abort occupies cycle TMO+1 and the error ack cycle TMO+2.
    task automatic run_txn(input int rise, input int fall, input bit drop, output int g_seen);
        int         w;
        bit         ok;
        int         exp_ack;
        int         exp_abort;
        int         ack_t   = -1;
        int         abort_t = -1;
        int         aborts  = 0;
        int         gos     = 0;
        int         unstable = 0;
        logic [3:0] ack_vec = '0;
        logic       err     = 1'b0;

        w         = rr_winner();
        ok        = (rise > 0) && (fall > rise) && (fall <= TMO);
        exp_ack   = ok ? fall + 1 : TMO + 2;
        exp_abort = ok ? -1 : TMO + 1;

        @(negedge clk);
        g_seen = int'(grant_id);
        check_eq("go", 32'(drv_go), 32'd1);
        check_eq("grant", 32'(grant_id), 32'(w));
        check_eq("active", 32'(active), 32'd1);
        check_eq("fields", 32'({drv_addr, drv_rw, drv_data}),
                 32'({m_addr[w], m_rw[w], m_data[w]}));

        for (int t = 1; t <= TMO + 3 && ack_t < 0; t++) begin
            @(negedge clk);
            drv_busy = busy_prof(t, rise, fall);
            if (drop && t == 2) begin
                m_valid[w] = 1'b0;
                drive_reqs();
            end
            if (drv_go) gos++;
            if ({drv_addr, drv_rw, drv_data} !== {m_addr[w], m_rw[w], m_data[w]}) unstable++;
            if (drv_abort) begin
                aborts++;
                if (abort_t < 0) abort_t = t;
            end
            if (req_ack != 4'd0) begin
                ack_t   = t;
                ack_vec = req_ack;
                err     = req_err;
            end
        end
        drv_busy = 1'b0;

        check_eq("ack_cycle", 32'(ack_t), 32'(exp_ack));
        check_eq("abort_cycle", 32'(abort_t), 32'(exp_abort));
        check_eq("abort_count", 32'(aborts), ok ? 32'd0 : 32'd1);
        check_eq("ack_vec", 32'(ack_vec), 32'(4'b0001 << w));
        check_eq("ack_err", 32'(err), ok ? 32'd0 : 32'd1);
        check_eq("no_regrant", 32'(gos), 32'd0);
        check_eq("fields_stable", 32'(unstable), 32'd0);
        m_last = w;
    endtask

    // From the ack negedge: GAP cycles active with no grant, then one IDLE cycle
    task automatic gap_phase();
        int bad = 0;
        for (int g = 0; g < GP; g++) begin
            @(negedge clk);
            if (!active || drv_go || req_ack != 4'd0) bad++;
        end
        check_eq("gap_hold", 32'(bad), 32'd0);
        @(negedge clk);
        check_eq("idle_inactive", 32'({active, drv_go}), 32'd0);
    endtask

    initial begin
        int g;
        int rise;
        int fall;
        bit drop;

        for (int i = 0; i < 4; i++) new_fields(i);
        m_valid  = 4'hF;
        m_last   = 3;
        drv_busy = 1'b0;
        drive_reqs();

        // Reset with every requester asserting
        apply_reset(3);

        // Fairness: all requesters stay valid, grants rotate 0,1,2,3,0
        for (int n = 0; n < 5; n++) begin
            rise = 1 + int'($urandom_range(3, 0));
            fall = rise + 1 + int'($urandom_range(9, 0));
            run_txn(rise, fall, 1'b0, g);
            check_eq("fair_order", 32'(g), 32'(n % 4));
            if (n == 4) m_valid = 4'h0;
            else new_fields(g);
            drive_reqs();
            gap_phase();
        end

        // Single write from requester 0
        m_valid   = 4'b0001;
        m_addr[0] = 7'h27;
        m_data[0] = 8'hA5;
        m_rw[0]   = 1'b0;
        drive_reqs();
        run_txn(1, 13, 1'b0, g);
        m_valid = 4'h0;
        drive_reqs();
        gap_phase();

        // Directed profiles: stuck busy, busy never rises, last-cycle finish,
        // one cycle too late, valid dropped after grant
        for (int d = 0; d < 5; d++) begin
            m_valid = 4'(1 << (d % 4)) | 4'($urandom);
            drive_reqs();
            case (d)
                0:       run_txn(1, 0, 1'b0, g);
                1:       run_txn(0, 0, 1'b0, g);
                2:       run_txn(2, TMO, 1'b0, g);
                3:       run_txn(3, TMO + 1, 1'b0, g);
                default: run_txn(2, 7, 1'b1, g);
            endcase
            m_valid[g] = 1'b0;
            drive_reqs();
            gap_phase();
        end

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            if (m_valid == 4'h0) begin
                repeat ($urandom_range(2, 0)) @(negedge clk);
                m_valid = 4'($urandom_range(15, 1));
                for (int i = 0; i < 4; i++) if (m_valid[i]) new_fields(i);
                drive_reqs();
            end
            rise = 1 + int'($urandom_range(3, 0));
            fall = rise + 1 + int'($urandom_range(9, 0));
            case ($urandom_range(9, 0))
                0:       fall = 0;
                1:       rise = 0;
                default: ;
            endcase
            drop = ($urandom_range(5, 0) == 0);
            run_txn(rise, fall, drop, g);
            if (m_valid[g] && $urandom_range(1, 0) == 1) m_valid[g] = 1'b0;
            else if (m_valid[g]) new_fields(g);
            for (int i = 0; i < 4; i++) begin
                if (!m_valid[i] && i != g && $urandom_range(2, 0) == 0) begin
                    new_fields(i);
                    m_valid[i] = 1'b1;
                end
            end
            drive_reqs();
            gap_phase();
        end

        // Reset while waiting for busy to drop, then first grant goes to req0
        m_valid = 4'b0010;
        drive_reqs();
        @(negedge clk);
        check_eq("mid_go", 32'(drv_go), 32'd1);
        drv_busy = 1'b1;
        repeat (4) @(negedge clk);
        check_eq("mid_active", 32'(active), 32'd1);
        m_valid = 4'hF;
        drive_reqs();
        apply_reset(3);
        run_txn(1, 5, 1'b0, g);
        check_eq("post_reset_grant", 32'(g), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
